// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: captures request lines into a pending register and
// presents the highest-index unmasked pending request on a valid/ack handshake.
// EDGE_MODE=1 latches rising edges (with overrun tracking), EDGE_MODE=0 mirrors
// the registered request level.
module irq_pending_arbiter #(
  parameter bit EDGE_MODE = 1'b1,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             id_ack,
  input  logic             ovr_clr,
  output logic [2:0]       id_out,
  output logic             id_valid,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overrun
);

  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   req_q_reg;
  logic [WIDTH-1:0]   pending_reg, pending_next;
  logic [WIDTH-1:0]   overrun_reg, overrun_next;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   ack_clr;
  logic [WIDTH-1:0]   eligible;
  logic [IDX_W-1:0]   id_reg, id_next;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               ack_fire;

  // An ack only counts while a request is actually being presented.
  assign ack_fire = (state_reg == PRESENT) && id_ack;
  assign rise     = req_in & ~req_q_reg;
  assign eligible = pending_reg & ~mask;

  // Per-bit pending / overrun next state. A new edge beats a same-cycle ack
  // clear, and an edge on the bit being acked is not an overrun.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign ack_clr[gi] = ack_fire && (id_reg == IDX_W'(gi));
      if (EDGE_MODE) begin : g_edge
        assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~ack_clr[gi]);
        assign overrun_next[gi] = (rise[gi] & pending_reg[gi] & ~ack_clr[gi])
                                | (overrun_reg[gi] & ~ovr_clr);
      end else begin : g_level
        assign pending_next[gi] = req_in[gi];
        assign overrun_next[gi] = 1'b0;
      end
    end
  endgenerate

  // MSB-priority selection: the highest eligible index wins.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (eligible[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  // Handshake FSM: latch a selection in IDLE, freeze it in PRESENT until ack.
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          id_next    = sel_idx;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (id_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Input stage, pending and overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q_reg   <= '0;
      pending_reg <= '0;
      overrun_reg <= '0;
    end else begin
      req_q_reg   <= req_in;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  // FSM state and presented index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  assign id_out   = id_reg;
  assign id_valid = (state_reg == PRESENT);
  assign pending  = pending_reg;
  assign overrun  = overrun_reg;

endmodule
